fpu_ret_collector: RTL and testbench



---
 rtl/fpu_ret_collector.sv | 130 +++++++++++++
 tb/tb_fpu_ret_collector.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ret_collector.sv
// FPU lane return collector: compacts up to three returns per cycle into an
// in-order FIFO, drains one per cycle to retire and accumulates sticky flags.
module fpu_ret_collector #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              fpcsr,
   input  logic [13:0]              u1_ret,
   input  logic [13:0]              u3_ret,
   input  logic [13:0]              u5_ret,
   input  logic                     u1_ret_en,
   input  logic                     u3_ret_en,
   input  logic                     u5_ret_en,
   output logic                     ret_stall,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [7:0]               out_id,
   output logic [5:0]               out_flags,
   output logic                     out_trap,
   input  logic                     flush,
   input  logic                     csr_wr_en,
   input  logic [5:0]               csr_wr_data,
   output logic [5:0]               sticky_flags,
   output logic                     overflow_err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [13:0]   mem_q [DEPTH];
   logic [13:0]   mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [5:0]    sticky_flags_q, sticky_flags_d;
   logic          overflow_err_q, overflow_err_d;

   logic [13:0]   lane_ret [3];
   logic [2:0]    lane_en;
   logic [13:0]   head_ent;
   logic [CW-1:0] free;
   logic [1:0]    n_acc;
   logic [PW-1:0] wr_idx;
   logic          drop;
   logic          pop;

   assign lane_ret[0] = u1_ret;
   assign lane_ret[1] = u3_ret;
   assign lane_ret[2] = u5_ret;
   assign lane_en     = {u5_ret_en, u3_ret_en, u1_ret_en};

   assign head_ent  = mem_q[head_q];
   assign free      = CW'(DEPTH) - count_q;
   assign out_vld   = (count_q != '0);
   assign ret_stall = (count_q >= CW'(DEPTH - 2));
   assign out_id    = head_ent[13:6];
   assign out_flags = head_ent[5:0];
   assign out_trap  = out_vld & (|(head_ent[5:0] & fpcsr[12:7]));
   assign pop       = out_vld & out_rdy;

   assign sticky_flags = sticky_flags_q;
   assign overflow_err = overflow_err_q;
   assign count        = count_q;

   // Free space comes from the registered count only, so a same-cycle pop
   // never makes room for a lane in that cycle.
   always_comb begin
      mem_d  = mem_q;
      n_acc  = 2'd0;
      drop   = 1'b0;
      wr_idx = tail_q;
      if (!flush) begin
         for (int i = 0; i < 3; i++) begin
            if (lane_en[i]) begin
               if (CW'(n_acc) < free) begin
                  wr_idx        = tail_q + PW'(n_acc);
                  mem_d[wr_idx] = lane_ret[i];
                  n_acc         = n_acc + 2'd1;
               end else begin
                  drop = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      overflow_err_d = overflow_err_q | drop;
      sticky_flags_d = (csr_wr_en ? csr_wr_data : sticky_flags_q)
                     | (pop ? head_ent[5:0] : 6'd0);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(pop);
         tail_d  = tail_q + PW'(n_acc);
         count_d = count_q + CW'(n_acc) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         sticky_flags_q <= '0;
         overflow_err_q <= 1'b0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         sticky_flags_q <= sticky_flags_d;
         overflow_err_q <= overflow_err_d;
      end
   end

   // Payload storage carries no reset; occupancy alone qualifies it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: tb/tb_fpu_ret_collector.sv
// Directed bench for fpu_ret_collector: ordering, stall/overflow, traps,
// sticky flags, CSR collision, flush and the no-bypass full boundary.
module tb_fpu_ret_collector;

   logic        clk;
   logic        rst;
   logic [31:0] fpcsr;
   logic [13:0] u1_ret, u3_ret, u5_ret;
   logic        u1_ret_en, u3_ret_en, u5_ret_en;
   logic        ret_stall;
   logic        out_vld;
   logic        out_rdy;
   logic [7:0]  out_id;
   logic [5:0]  out_flags;
   logic        out_trap;
   logic        flush;
   logic        csr_wr_en;
   logic [5:0]  csr_wr_data;
   logic [5:0]  sticky_flags;
   logic        overflow_err;
   logic [3:0]  count;

   int tests = 0;
   int fails = 0;

   fpu_ret_collector #(.DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .fpcsr        (fpcsr),
      .u1_ret       (u1_ret),
      .u3_ret       (u3_ret),
      .u5_ret       (u5_ret),
      .u1_ret_en    (u1_ret_en),
      .u3_ret_en    (u3_ret_en),
      .u5_ret_en    (u5_ret_en),
      .ret_stall    (ret_stall),
      .out_vld      (out_vld),
      .out_rdy      (out_rdy),
      .out_id       (out_id),
      .out_flags    (out_flags),
      .out_trap     (out_trap),
      .flush        (flush),
      .csr_wr_en    (csr_wr_en),
      .csr_wr_data  (csr_wr_data),
      .sticky_flags (sticky_flags),
      .overflow_err (overflow_err),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lanes(input logic [2:0] en,
                        input logic [7:0] i1, input logic [5:0] f1,
                        input logic [7:0] i3, input logic [5:0] f3,
                        input logic [7:0] i5, input logic [5:0] f5);
      u1_ret_en = en[0];
      u3_ret_en = en[1];
      u5_ret_en = en[2];
      u1_ret    = {i1, f1};
      u3_ret    = {i3, f3};
      u5_ret    = {i5, f5};
   endtask

   task automatic idle_lanes();
      u1_ret_en = 1'b0;
      u3_ret_en = 1'b0;
      u5_ret_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      lanes(3'b111, 8'h01, 6'h3f, 8'h02, 6'h3f, 8'h03, 6'h3f);
      out_rdy = 1'b1;
      step();
      step();
      rst = 1'b0;
      idle_lanes();
      out_rdy = 1'b0;
      step();
      tests++;
      if (count !== 4'd0) begin
         fails++;
         $display("FAIL reset_count: got %0d want 0", count);
      end
      tests++;
      if (out_vld !== 1'b0 || ret_stall !== 1'b0) begin
         fails++;
         $display("FAIL reset_vld_stall: got vld=%b stall=%b want 0 0",
                  out_vld, ret_stall);
      end
      tests++;
      if (sticky_flags !== 6'd0 || overflow_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_sticky_ovf: got %b %b want 000000 0",
                  sticky_flags, overflow_err);
      end
   endtask

   task automatic test_ordering();
      logic [7:0] exp_id [3];
      exp_id[0] = 8'h10;
      exp_id[1] = 8'h11;
      exp_id[2] = 8'h12;
      out_rdy = 1'b1;
      lanes(3'b111, 8'h10, 6'd0, 8'h11, 6'd0, 8'h12, 6'd0);
      step();
      idle_lanes();
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (out_vld !== 1'b1 || out_id !== exp_id[i]) begin
            fails++;
            $display("FAIL order_%0d: got vld=%b id=%h want 1 %h",
                     i, out_vld, out_id, exp_id[i]);
         end
         step();
      end
      tests++;
      if (out_vld !== 1'b0 || count !== 4'd0) begin
         fails++;
         $display("FAIL order_empty: got vld=%b count=%0d want 0 0",
                  out_vld, count);
      end
      step();
      tests++;
      if (count !== 4'd0 || sticky_flags !== 6'd0) begin
         fails++;
         $display("FAIL rdy_when_empty: got count=%0d sticky=%b want 0 0",
                  count, sticky_flags);
      end
      out_rdy = 1'b0;
   endtask

   task automatic test_stall_overflow();
      out_rdy = 1'b0;
      lanes(3'b111, 8'h30, 6'd0, 8'h31, 6'd0, 8'h32, 6'd0);
      step();
      tests++;
      if (count !== 4'd3 || ret_stall !== 1'b0) begin
         fails++;
         $display("FAIL stall_at3: got count=%0d stall=%b want 3 0",
                  count, ret_stall);
      end
      lanes(3'b111, 8'h33, 6'd0, 8'h34, 6'd0, 8'h35, 6'd0);
      step();
      tests++;
      if (count !== 4'd6 || ret_stall !== 1'b1 || overflow_err !== 1'b0) begin
         fails++;
         $display("FAIL stall_at6: got count=%0d stall=%b ovf=%b want 6 1 0",
                  count, ret_stall, overflow_err);
      end
      lanes(3'b111, 8'h36, 6'd0, 8'h37, 6'd0, 8'h38, 6'd0);
      step();
      idle_lanes();
      tests++;
      if (count !== 4'd8 || overflow_err !== 1'b1) begin
         fails++;
         $display("FAIL overflow: got count=%0d ovf=%b want 8 1",
                  count, overflow_err);
      end
      tests++;
      if (out_id !== 8'h30) begin
         fails++;
         $display("FAIL head_stable: got %h want 30", out_id);
      end
      out_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (out_vld !== 1'b1 || out_id !== 8'(8'h30 + i)) begin
            fails++;
            $display("FAIL drain_%0d: got vld=%b id=%h want 1 %h",
                     i, out_vld, out_id, 8'(8'h30 + i));
         end
         step();
      end
      tests++;
      if (out_vld !== 1'b0 || overflow_err !== 1'b1) begin
         fails++;
         $display("FAIL drain_end: got vld=%b ovf=%b want 0 1",
                  out_vld, overflow_err);
      end
      out_rdy = 1'b0;
   endtask

   task automatic test_reset_midop();
      lanes(3'b111, 8'h70, 6'h3f, 8'h71, 6'h3f, 8'h72, 6'h3f);
      csr_wr_en   = 1'b1;
      csr_wr_data = 6'h3f;
      flush       = 1'b1;
      rst         = 1'b1;
      step();
      rst         = 1'b0;
      flush       = 1'b0;
      csr_wr_en   = 1'b0;
      idle_lanes();
      tests++;
      if (count !== 4'd0 || overflow_err !== 1'b0 || sticky_flags !== 6'd0) begin
         fails++;
         $display("FAIL reset_midop: got count=%0d ovf=%b sticky=%b want 0 0 0",
                  count, overflow_err, sticky_flags);
      end
   endtask

   task automatic test_trap_sticky();
      fpcsr = 32'd0;
      fpcsr[12:7] = 6'b000100;
      out_rdy = 1'b0;
      lanes(3'b001, 8'h20, 6'b000100, 8'h0, 6'd0, 8'h0, 6'd0);
      step();
      idle_lanes();
      tests++;
      if (out_vld !== 1'b1 || out_id !== 8'h20 || out_trap !== 1'b1) begin
         fails++;
         $display("FAIL trap_set: got vld=%b id=%h trap=%b want 1 20 1",
                  out_vld, out_id, out_trap);
      end
      out_rdy = 1'b1;
      step();
      out_rdy = 1'b0;
      tests++;
      if (sticky_flags !== 6'b000100 || out_trap !== 1'b0) begin
         fails++;
         $display("FAIL sticky_1: got sticky=%b trap=%b want 000100 0",
                  sticky_flags, out_trap);
      end
      lanes(3'b001, 8'h21, 6'b000010, 8'h0, 6'd0, 8'h0, 6'd0);
      step();
      idle_lanes();
      tests++;
      if (out_id !== 8'h21 || out_trap !== 1'b0) begin
         fails++;
         $display("FAIL trap_clear: got id=%h trap=%b want 21 0",
                  out_id, out_trap);
      end
      out_rdy = 1'b1;
      step();
      out_rdy = 1'b0;
      tests++;
      if (sticky_flags !== 6'b000110) begin
         fails++;
         $display("FAIL sticky_2: got %b want 000110", sticky_flags);
      end
   endtask

   task automatic test_csr_collision();
      csr_wr_en   = 1'b1;
      csr_wr_data = 6'b111111;
      step();
      csr_wr_en = 1'b0;
      tests++;
      if (sticky_flags !== 6'b111111) begin
         fails++;
         $display("FAIL csr_write: got %b want 111111", sticky_flags);
      end
      lanes(3'b001, 8'h22, 6'b000001, 8'h0, 6'd0, 8'h0, 6'd0);
      step();
      idle_lanes();
      out_rdy     = 1'b1;
      csr_wr_en   = 1'b1;
      csr_wr_data = 6'b000000;
      step();
      out_rdy   = 1'b0;
      csr_wr_en = 1'b0;
      tests++;
      if (sticky_flags !== 6'b000001 || out_vld !== 1'b0) begin
         fails++;
         $display("FAIL csr_collision: got sticky=%b vld=%b want 000001 0",
                  sticky_flags, out_vld);
      end
   endtask

   task automatic test_flush();
      out_rdy = 1'b0;
      lanes(3'b111, 8'h40, 6'b001000, 8'h41, 6'd0, 8'h42, 6'd0);
      step();
      lanes(3'b011, 8'h43, 6'd0, 8'h44, 6'd0, 8'h0, 6'd0);
      step();
      tests++;
      if (count !== 4'd5) begin
         fails++;
         $display("FAIL flush_pre: got count=%0d want 5", count);
      end
      flush = 1'b1;
      lanes(3'b001, 8'h50, 6'b010000, 8'h0, 6'd0, 8'h0, 6'd0);
      step();
      flush = 1'b0;
      idle_lanes();
      tests++;
      if (count !== 4'd0 || out_vld !== 1'b0 || sticky_flags !== 6'b000001) begin
         fails++;
         $display("FAIL flush: got count=%0d vld=%b sticky=%b want 0 0 000001",
                  count, out_vld, sticky_flags);
      end
      step();
      tests++;
      if (count !== 4'd0 || out_vld !== 1'b0) begin
         fails++;
         $display("FAIL flush_drop: got count=%0d vld=%b want 0 0",
                  count, out_vld);
      end
      lanes(3'b001, 8'h51, 6'b001000, 8'h0, 6'd0, 8'h0, 6'd0);
      step();
      idle_lanes();
      tests++;
      if (out_vld !== 1'b1 || out_id !== 8'h51 || count !== 4'd1) begin
         fails++;
         $display("FAIL post_flush: got vld=%b id=%h count=%0d want 1 51 1",
                  out_vld, out_id, count);
      end
      flush   = 1'b1;
      out_rdy = 1'b1;
      step();
      flush   = 1'b0;
      out_rdy = 1'b0;
      tests++;
      if (sticky_flags !== 6'b001001 || count !== 4'd0) begin
         fails++;
         $display("FAIL flush_pop: got sticky=%b count=%0d want 001001 0",
                  sticky_flags, count);
      end
   endtask

   task automatic test_no_bypass();
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_rdy = 1'b0;
      lanes(3'b111, 8'h60, 6'd0, 8'h61, 6'd0, 8'h62, 6'd0);
      step();
      lanes(3'b111, 8'h63, 6'd0, 8'h64, 6'd0, 8'h65, 6'd0);
      step();
      out_rdy = 1'b1;
      lanes(3'b111, 8'h66, 6'd0, 8'h67, 6'd0, 8'h68, 6'd0);
      step();
      idle_lanes();
      tests++;
      if (count !== 4'd7 || overflow_err !== 1'b1 || out_id !== 8'h61) begin
         fails++;
         $display("FAIL no_bypass: got count=%0d ovf=%b id=%h want 7 1 61",
                  count, overflow_err, out_id);
      end
      for (int i = 1; i < 8; i++) begin
         tests++;
         if (out_vld !== 1'b1 || out_id !== 8'(8'h60 + i)) begin
            fails++;
            $display("FAIL nb_drain_%0d: got vld=%b id=%h want 1 %h",
                     i, out_vld, out_id, 8'(8'h60 + i));
         end
         step();
      end
      tests++;
      if (out_vld !== 1'b0 || count !== 4'd0) begin
         fails++;
         $display("FAIL nb_empty: got vld=%b count=%0d want 0 0",
                  out_vld, count);
      end
      out_rdy = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      fpcsr       = 32'd0;
      out_rdy     = 1'b0;
      flush       = 1'b0;
      csr_wr_en   = 1'b0;
      csr_wr_data = 6'd0;
      idle_lanes();
      u1_ret = 14'd0;
      u3_ret = 14'd0;
      u5_ret = 14'd0;
      test_reset();
      test_ordering();
      test_stall_overflow();
      test_reset_midop();
      test_trap_sticky();
      test_csr_collision();
      test_flush();
      test_no_bypass();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
